fxp_wsum_seq: RTL

Parametrised, time-multiplexed fixed-point weighted summer: computes y = Σ kᵢ·xᵢ over NCH channels using one shared multiplier and an accumulator. It is the sequential, generalised successor of the 3-channel combinational 12×12 multiply/sum datapath, adding three things that datapath lacks:
- programmable coefficients;
- valid/ready handshakes;
- a selectable saturate or wrap output mode.

It sits between a sample source and a downstream consumer in the DSP path.

---
 rtl/fxp_wsum_pkg.sv | 39 +++
 rtl/fxp_wsum_seq_mul.sv | 18 +
 rtl/fxp_wsum_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fxp_wsum_pkg.sv
// Shared types and helpers for the time-multiplexed fixed-point weighted summer.
// The saturate/wrap helpers take widths as arguments so any block can reuse them.
package fxp_wsum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_e;

    localparam int GUARD_DEFAULT = 2;

    // Wrap mode returns r unchanged; the caller truncates it to xw bits.
    function automatic logic signed [63:0] sat_wrap(input logic signed [63:0] r,
                                                    input int xw,
                                                    input bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (xw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (xw - 1));
        if (!sat)
            return r;
        if (r > hi)
            return hi;
        if (r < lo)
            return lo;
        return r;
    endfunction

    function automatic logic out_of_range(input logic signed [63:0] r,
                                          input int xw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (xw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (xw - 1));
        return (r > hi) || (r < lo);
    endfunction

endpackage

// File: rtl/fxp_wsum_seq_mul.sv
// Signed W x KW multiply with the product's top bit dropped and the KW-1
// fractional LSBs discarded, leaving a W-bit result in the sample format.
module fxp_mul_trunc #(
    parameter int W  = 12,
    parameter int KW = 12
) (
    input  logic signed [W-1:0]  a,
    input  logic signed [KW-1:0] b,
    output logic signed [W-1:0]  p
);

    // Holding only W+KW-1 bits drops the product MSB as intended.
    logic signed [W+KW-2:0] prod;

    assign prod = a * b;
    assign p    = W'(prod >>> (KW - 1));

endmodule

// File: rtl/fxp_wsum_seq.sv
// Weighted sum y = sum(k_i * x_i) over NCH channels, one channel per clock
// through a single shared multiplier, with a saturate or wrap output stage.
module fxp_wsum_seq
    import fxp_wsum_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int XW    = 10,
    parameter int KW    = 12,
    parameter int GUARD = GUARD_DEFAULT,
    parameter int SAT   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCH*XW-1:0]        x,
    input  logic                     coef_we,
    input  logic [$clog2(NCH)-1:0]   coef_addr,
    input  logic [KW-1:0]            coef_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XW-1:0]            y,
    output logic                     out_sat
);

    localparam int W    = XW + GUARD;
    localparam int CHW  = $clog2(NCH);
    localparam int ACCW = W + $clog2(NCH);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid, once raised, holds with its data until that edge.
    state_e                  state_q, state_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [NCH*XW-1:0]       x_q, x_d;
    logic [XW-1:0]           y_q, y_d;
    logic                    sat_q, sat_d;
    logic [KW-1:0]           coef_q [NCH];
    logic [KW-1:0]           coef_d [NCH];

    logic [XW-1:0]           x_sel;
    logic signed [W-1:0]     v_ch;
    logic signed [KW-1:0]    k_ch;
    logic signed [W-1:0]     p_ch;
    logic signed [ACCW-1:0]  acc_sum;
    logic signed [ACCW-1:0]  r;

    assign x_sel = x_q[int'(ch_q)*XW +: XW];
    assign v_ch  = W'($signed(x_sel)) <<< GUARD;
    assign k_ch  = $signed(coef_q[ch_q]);

    fxp_mul_trunc #(
        .W  (W),
        .KW (KW)
    ) u_mul (
        .a (v_ch),
        .b (k_ch),
        .p (p_ch)
    );

    assign acc_sum = acc_q + ACCW'(p_ch);
    assign r       = acc_sum >>> GUARD;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        sat_d   = sat_q;
        coef_d  = coef_q;
        case (state_q)
            IDLE: begin
                // The write lands on the same edge as capture, so MAC sees it.
                if (coef_we && (int'(coef_addr) < NCH))
                    coef_d[coef_addr] = coef_wdata;
                if (in_valid) begin
                    x_d     = x;
                    acc_d   = '0;
                    ch_d    = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                ch_d  = ch_q + 1'b1;
                if (ch_q == CHW'(NCH - 1)) begin
                    ch_d    = '0;
                    y_d     = XW'(sat_wrap(64'(r), XW, SAT != 0));
                    sat_d   = out_of_range(64'(r), XW);
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < NCH; i++)
                coef_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
            coef_q  <= coef_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign y         = y_q;
    assign out_sat   = sat_q;

endmodule
